tiled_matrix_multiplier: RTL
============================

Name: tiled_matrix_multiplier

Overview:
Parametrised successor to the single-width parallel multiplier. Computes R = A x B for N x N integer matrices held in internal A/B/R arrays, using LANES parallel MAC lanes that each produce one output column of a column group per pass. Adds over the previous generation: configurable data and accumulator width, signed/unsigned mode, clock-synchronous load ports, a busy/done handshake and a registered read port. Sits between the host load/readout logic and downstream consumers of R.

Parameters:
N, 8, matrix dimension; must be ≥ 2.
W, 16, operand width in bits.
LANES, 4, parallel MAC lanes; N mod LANES must be 0.
IDX_W, $clog2(N), index width (derived).
ACC_W, 2*W+$clog2(N), accumulator/result width (derived, lossless).

Ports:
clk  in  1  single clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
signed_mode  in  1  1 = two's-complement operands; latched at accepted start.
a_we  in  1  synchronous write enable for A.
a_i, a_j  in  IDX_W  A write row/column.
a_in  in  W  A write data.
b_we  in  1  synchronous write enable for B.
b_i, b_j  in  IDX_W  B write row/column.
b_in  in  W  B write data.
z_i, z_j  in  IDX_W  R read row/column.
z_out  out  ACC_W  R[z_i][z_j], registered, 1-cycle latency.
busy  out  1  high while a multiply is running.
done  out  1  one-cycle pulse when R is complete.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, z_out=0; counters and accumulators cleared. A/B/R arrays are not reset.
- Reset mid-operation: aborts immediately; R keeps only groups written before reset; no done pulse.
- A/B writes: on posedge clk when we=1 and busy=0. Writes while busy=1 are dropped. Simultaneous a_we and b_we are both honoured.
- FSM: IDLE -> RUN on start (busy rises the next cycle). RUN -> WB after k reaches N-1. WB -> RUN for the next group/row, or -> FIN after the last one. FIN -> IDLE with done=1 and busy=0 in that same cycle.
- RUN: one k per cycle. Lane l computes acc_l += A[i][k]*B[k][g*LANES+l]. The product is sign- or zero-extended to ACC_W according to latched signed_mode. Accumulators clear at k=0.
- WB: one cycle; writes all LANES results R[i][g*LANES+l] = acc_l. Then g increments; g wraps to 0 with i+1.
- Iteration order: i outer (0..N-1), g inner (0..N/LANES-1).
- Latency: done is high exactly N*(N/LANES)*(N+1)+1 cycles after the clock edge that samples start.
- start while busy or in FIN: ignored, no queuing. signed_mode changes mid-run have no effect.
- z_out updates every cycle from R, including during a run. Mid-run readouts return stale/partial data; this is legal but undefined for the checker.
- No overflow is possible: ACC_W is lossless. Unsigned results are zero-extended; signed results are two's complement.

Decomposition:
- Package tmm_pkg: FSM state enum (IDLE, RUN, WB, FIN) and a width helper function for ACC_W.
- Sub-module mac_lane (params W, ACC_W): inputs clr, en, signed_mode, a, b; registered acc output. Instantiate LANES copies via generate.

Test Plan:
- N=4, LANES=2, W=8. A=identity, B[r][c]=4r+c, unsigned, start -> done at cycle 41; every R[r][c] reads 4r+c.
- A and B all 0xFF, signed_mode=1 -> every R = +4 (ACC_W=18, 0x00004). Same data with signed_mode=0 -> every R = 260100.
- A all 0xFF, B all 0x02: signed -> every R = -8 (0x3FFF8); unsigned -> 2040.
- start re-pulsed at cycles 5 and 20 of a run, plus an a_we write of 0x7F to A[0][0] during the run -> done still at cycle 41 only, results unchanged, A[0][0] retains its old value.
- rst asserted at cycle 15 of a run -> busy=0 and done=0 immediately, z_out=0, no done pulse. A new start then completes correctly at cycle 41.
- Readout sweep after done: z_i/z_j stepped each cycle -> z_out follows with exactly 1-cycle lag.

Source files
------------

// File: rtl/tmm_pkg.sv
// tmm_pkg: FSM state encoding and accumulator width helper for the tiled matrix multiplier
package tmm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, WB, FIN} state_t;
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction
endpackage

// File: rtl/tiled_matrix_multiplier_if.sv
// tiled_matrix_multiplier_if: host bus (start/signed_mode, A/B write ports, R read port z_i/z_j/z_out, busy/done)
interface tiled_matrix_multiplier_if import tmm_pkg::*; #(
  parameter int N = 8,
  parameter int W = 16
) ();
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = acc_width(W, N);
  logic start, signed_mode;
  logic a_we, b_we;
  logic [IDX_W-1:0] a_i, a_j, b_i, b_j, z_i, z_j;
  logic [W-1:0] a_in, b_in;
  logic [ACC_W-1:0] z_out;
  logic busy, done;
  modport master (
    output start, signed_mode, a_we, a_i, a_j, a_in, b_we, b_i, b_j, b_in, z_i, z_j,
    input z_out, busy, done
  );
  modport slave (
    input start, signed_mode, a_we, a_i, a_j, a_in, b_we, b_i, b_j, b_in, z_i, z_j,
    output z_out, busy, done
  );
endinterface

// File: rtl/tiled_matrix_multiplier_mac_lane.sv
// mac_lane: one MAC lane (clk, rst, clr, en, signed_mode, a, b -> registered acc), product sign/zero-extended to ACC_W
module mac_lane #(
  parameter int W = 16,
  parameter int ACC_W = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             signed_mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] acc
);
  logic [2*W-1:0] p_s, p_u;
  logic [ACC_W-1:0] p;
  always_comb begin
    p_s = (2*W)'($signed(a)) * (2*W)'($signed(b));
    p_u = (2*W)'(a) * (2*W)'(b);
    p = signed_mode ? {{(ACC_W-2*W){p_s[2*W-1]}}, p_s} : {{(ACC_W-2*W){1'b0}}, p_u};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (en) acc <= clr ? p : acc + p;
endmodule

// File: rtl/tiled_matrix_multiplier.sv
// tiled_matrix_multiplier: R = A x B over N x N arrays with LANES MAC lanes per column group (clk, rst, bus.slave)
module tiled_matrix_multiplier import tmm_pkg::*; #(
  parameter int N = 8,
  parameter int W = 16,
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst,
  tiled_matrix_multiplier_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = acc_width(W, N);
  localparam int G = N / LANES;
  state_t state;
  logic [IDX_W-1:0] i, k, g;
  logic sm, busy, done;
  logic [W-1:0] a_mem [N][N];
  logic [W-1:0] b_mem [N][N];
  logic [ACC_W-1:0] r_mem [N][N];
  logic [ACC_W-1:0] acc [LANES];
  logic [IDX_W-1:0] col [LANES];
  logic [ACC_W-1:0] z_q;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign col[l] = IDX_W'(int'(g) * LANES + l);
    mac_lane #(.W(W), .ACC_W(ACC_W)) u_lane (
      .clk(clk), .rst(rst), .clr(k == '0), .en(state == RUN), .signed_mode(sm),
      .a(a_mem[i][k]), .b(b_mem[k][col[l]]), .acc(acc[l])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sm <= 1'b0;
      i <= '0;
      k <= '0;
      g <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          busy <= 1'b1;
          sm <= bus.signed_mode;
          i <= '0;
          k <= '0;
          g <= '0;
        end
        RUN: begin
          k <= (k == IDX_W'(N-1)) ? '0 : k + 1'b1;
          if (k == IDX_W'(N-1)) state <= WB;
        end
        WB: begin
          g <= (g == IDX_W'(G-1)) ? '0 : g + 1'b1;
          i <= (g == IDX_W'(G-1) && i != IDX_W'(N-1)) ? i + 1'b1 : i;
          state <= (g == IDX_W'(G-1) && i == IDX_W'(N-1)) ? FIN : RUN;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  always_ff @(posedge clk) begin
    if (bus.a_we && !busy) a_mem[bus.a_i][bus.a_j] <= bus.a_in;
    if (bus.b_we && !busy) b_mem[bus.b_i][bus.b_j] <= bus.b_in;
    if (state == WB) for (int l = 0; l < LANES; l++) r_mem[i][col[l]] <= acc[l];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) z_q <= '0;
    else z_q <= r_mem[bus.z_i][bus.z_j];
  assign bus.z_out = z_q;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
